// File: rtl/alu_seq_muldiv_if.sv
// Handshake bundle for alu_seq_muldiv.
// master: producer/consumer side; slave: the ALU itself.
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [4:0]       op_i;
  logic [WIDTH-1:0] rd_i;
  logic [WIDTH-1:0] rs_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             jump_now_o;
  logic             busy_o;

  modport master (
    output in_valid_i, op_i, rd_i, rs_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, jump_now_o, busy_o
  );

  modport slave (
    input  in_valid_i, op_i, rd_i, rs_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, jump_now_o, busy_o
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Handshaked ALU: 1-cycle ops plus WIDTH-cycle shift-add mul / restoring div.
// Ports: clk, n_reset (async low), bus (slave). Option: ALU_SIGNED_MULDIV_EN.
module alu_seq_muldiv #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             n_reset,
  alu_seq_muldiv_if.slave bus
);
  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd2;
  localparam logic [4:0] OP_SRA   = 5'd3;
  localparam logic [4:0] OP_SRL   = 5'd4;
  localparam logic [4:0] OP_AND   = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_NOR   = 5'd7;
  localparam logic [4:0] OP_XOR   = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_SLTU  = 5'd10;
  localparam logic [4:0] OP_ROL   = 5'd11;
  localparam logic [4:0] OP_ROR   = 5'd12;
  localparam logic [4:0] OP_BEQZ  = 5'd13;
  localparam logic [4:0] OP_BNEZ  = 5'd14;
  localparam logic [4:0] OP_BGTZ  = 5'd15;
  localparam logic [4:0] OP_BLTZ  = 5'd16;
  localparam logic [4:0] OP_MOV   = 5'd17;
  localparam logic [4:0] OP_MUL   = 5'd18;
  localparam logic [4:0] OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIVU  = 5'd20;
  localparam logic [4:0] OP_REMU  = 5'd21;
`ifdef ALU_SIGNED_MULDIV_EN
  localparam logic [4:0] OP_MULH  = 5'd22;
  localparam logic [4:0] OP_DIV   = 5'd23;
  localparam logic [4:0] OP_REM   = 5'd24;
`endif

  localparam logic [WIDTH-1:0]   ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};
  // WIDTH is a power of two, so the last step is all-ones.
  localparam logic [SHW-1:0]     CNT_LAST = {SHW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  typedef enum logic [1:0] {R_LO, R_HI, R_QUO, R_REM} rsel_e;

  state_e             state_q, state_d;
  rsel_e              rsel_q, rsel_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               jump_q, jump_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic               accept;
  logic [WIDTH-1:0]   rd, rs;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_jmp;
  logic               is_mul, is_div, neg_in;
  rsel_e              sel_in;
  logic [WIDTH-1:0]   rd_mag, rs_mag;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_t;
  logic               div_ge;
  logic [WIDTH-1:0]   div_r;
  logic [2*WIDTH-1:0] step_nx;
  logic [2*WIDTH-1:0] mul_full;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   fin;

  assign rd    = bus.rd_i;
  assign rs    = bus.rs_i;
  assign shamt = rs[SHW-1:0];

  assign bus.in_ready_o  = (state_q == S_IDLE) &&
                           (!out_valid_q || bus.out_ready_i);
  assign accept          = bus.in_valid_i && bus.in_ready_o;
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;
  assign bus.jump_now_o  = jump_q;
  assign bus.busy_o      = (state_q == S_MUL) || (state_q == S_DIV);

  always_comb begin
    alu_res = '0;
    alu_jmp = 1'b0;
    unique case (bus.op_i)
      OP_ADD:  alu_res = rd + rs;
      OP_SUB:  alu_res = rd - rs;
      OP_SLL:  alu_res = rd << shamt;
      OP_SRA:  alu_res = $signed(rd) >>> shamt;
      OP_SRL:  alu_res = rd >> shamt;
      OP_AND:  alu_res = rd & rs;
      OP_OR:   alu_res = rd | rs;
      OP_NOR:  alu_res = ~(rd | rs);
      OP_XOR:  alu_res = rd ^ rs;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          $signed(rd) < $signed(rs)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, rd < rs};
      // Shift by WIDTH yields 0, so amount 0 returns rd.
      OP_ROL:  alu_res = (rd << shamt) |
                         (rd >> (WIDTH - int'(shamt)));
      OP_ROR:  alu_res = (rd >> shamt) |
                         (rd << (WIDTH - int'(shamt)));
      OP_BEQZ: alu_jmp = (rd == '0);
      OP_BNEZ: alu_jmp = (rd != '0);
      OP_BGTZ: alu_jmp = !rd[WIDTH-1] && (rd != '0);
      OP_BLTZ: alu_jmp = rd[WIDTH-1];
      OP_MOV:  alu_res = rs;
      default: ;
    endcase
  end

`ifdef ALU_SIGNED_MULDIV_EN
  logic [WIDTH-1:0] rd_abs, rs_abs;
  assign rd_abs = rd[WIDTH-1] ? (~rd + ONE) : rd;
  assign rs_abs = rs[WIDTH-1] ? (~rs + ONE) : rs;
`endif

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    sel_in = R_LO;
    neg_in = 1'b0;
    rd_mag = rd;
    rs_mag = rs;
    unique case (bus.op_i)
      OP_MUL:   is_mul = 1'b1;
      OP_MULHU: begin is_mul = 1'b1; sel_in = R_HI;  end
      OP_DIVU:  begin is_div = 1'b1; sel_in = R_QUO; end
      OP_REMU:  begin is_div = 1'b1; sel_in = R_REM; end
`ifdef ALU_SIGNED_MULDIV_EN
      OP_MULH: begin
        is_mul = 1'b1;
        sel_in = R_HI;
        neg_in = rd[WIDTH-1] ^ rs[WIDTH-1];
        rd_mag = rd_abs;
        rs_mag = rs_abs;
      end
      OP_DIV: begin
        is_div = 1'b1;
        sel_in = R_QUO;
        // x/0 must stay all-ones, so never negate it.
        neg_in = (rd[WIDTH-1] ^ rs[WIDTH-1]) && (rs != '0);
        rd_mag = rd_abs;
        rs_mag = rs_abs;
      end
      OP_REM: begin
        is_div = 1'b1;
        sel_in = R_REM;
        neg_in = rd[WIDTH-1];
        rd_mag = rd_abs;
        rs_mag = rs_abs;
      end
`endif
      default: ;
    endcase
  end

  // acc = {hi, lo}. MUL: hi accumulates, lo holds the
  // multiplier. DIV: hi is the partial remainder, lo
  // shifts dividend bits out and quotient bits in.
  always_comb begin
    mul_add = acc_q[0] ? opb_q : {WIDTH{1'b0}};
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    div_t   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = div_t >= {1'b0, opb_q};
    div_r   = div_t[WIDTH-1:0] - opb_q;
    if (state_q == S_DIV)
      step_nx = {div_ge ? div_r : div_t[WIDTH-1:0],
                 acc_q[WIDTH-2:0], div_ge};
    else
      step_nx = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    mul_full = neg_q ? (~step_nx + ONE2) : step_nx;
    quo_fix  = step_nx[WIDTH-1:0];
    rem_fix  = step_nx[2*WIDTH-1:WIDTH];
    if (neg_q) begin
      quo_fix = ~quo_fix + ONE;
      rem_fix = ~rem_fix + ONE;
    end
    fin = '0;
    unique case (rsel_q)
      R_LO:    fin = mul_full[WIDTH-1:0];
      R_HI:    fin = mul_full[2*WIDTH-1:WIDTH];
      R_QUO:   fin = quo_fix;
      R_REM:   fin = rem_fix;
      default: fin = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready_i;
    result_d    = result_q;
    jump_d      = jump_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    cnt_d       = cnt_q;
    rsel_d      = rsel_q;
    neg_d       = neg_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul || is_div) begin
            state_d = is_mul ? S_MUL : S_DIV;
            acc_d   = {{WIDTH{1'b0}}, rd_mag};
            opb_d   = rs_mag;
            cnt_d   = '0;
            rsel_d  = sel_in;
            neg_d   = neg_in;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            jump_d      = alu_jmp;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = step_nx;
        cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = fin;
          jump_d      = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      jump_q      <= 1'b0;
      acc_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      rsel_q      <= R_LO;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      jump_q      <= jump_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      cnt_q       <= cnt_d;
      rsel_q      <= rsel_d;
      neg_q       <= neg_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Randomised + directed bench for alu_seq_muldiv (WIDTH=32).
// Reference model uses plain integer arithmetic.
module tb_alu_seq_muldiv;
  localparam int W = 32;

  typedef struct packed {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } stim_t;

  typedef struct packed {
    logic [W-1:0] r;
    logic         j;
  } exp_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  alu_seq_muldiv_if #(.WIDTH(W)) bus ();

  alu_seq_muldiv #(.WIDTH(W)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         e;
    int unsigned  sh;
    logic [63:0]  pu;
    longint       ps;
    sh  = int'(b[4:0]);
    pu  = {32'b0, a} * {32'b0, b};
    ps  = longint'($signed(a)) * longint'($signed(b));
    e.r = '0;
    e.j = 1'b0;
    case (op)
      5'd0:  e.r = a + b;
      5'd1:  e.r = a - b;
      5'd2:  e.r = a << sh;
      5'd3:  e.r = $signed(a) >>> sh;
      5'd4:  e.r = a >> sh;
      5'd5:  e.r = a & b;
      5'd6:  e.r = a | b;
      5'd7:  e.r = ~(a | b);
      5'd8:  e.r = a ^ b;
      5'd9:  e.r = ($signed(a) < $signed(b)) ? 1 : 0;
      5'd10: e.r = (a < b) ? 1 : 0;
      5'd11: e.r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      5'd12: e.r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
      5'd13: e.j = (a == 0);
      5'd14: e.j = (a != 0);
      5'd15: e.j = ($signed(a) > 0);
      5'd16: e.j = ($signed(a) < 0);
      5'd17: e.r = b;
      5'd18: e.r = pu[31:0];
      5'd19: e.r = pu[63:32];
      5'd20: e.r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd21: e.r = (b == 0) ? a : a % b;
`ifdef ALU_SIGNED_MULDIV_EN
      5'd22: e.r = ps[63:32];
      5'd23: begin
        if (b == 0) e.r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.r = a;
        else e.r = $signed(a) / $signed(b);
      end
      5'd24: begin
        if (b == 0) e.r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.r = 0;
        else e.r = $signed(a) % $signed(b);
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // Streams stim_q through the DUT with random backpressure.
  task automatic drive(input int rdy_pct, input int max_cyc,
                       output int first_acc, output int last_acc);
    stim_t cur;
    exp_t  e;
    bit    have;
    int    cyc;
    have = 0;
    cyc = 0;
    cur = '0;
    first_acc = -1;
    last_acc = -1;
    while ((stim_q.size() > 0 || have || exp_q.size() > 0)
           && cyc < max_cyc) begin
      @(negedge clk);
      if (!have && stim_q.size() > 0) begin
        cur = stim_q.pop_front();
        have = 1;
      end
      bus.in_valid_i  = have;
      bus.op_i        = cur.op;
      bus.rd_i        = cur.a;
      bus.rs_i        = cur.b;
      bus.out_ready_i = ($urandom_range(99) < rdy_pct);
      #1;
      if (bus.out_valid_o && bus.out_ready_i) begin
        chk("outq", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("res", bus.result_o, e.r);
          chk("jmp", bus.jump_now_o, e.j);
        end
      end
      if (have && bus.in_ready_o) begin
        exp_q.push_back(model(cur.op, cur.a, cur.b));
        have = 0;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      cyc++;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    chk("timeout", 64'(cyc >= max_cyc), 0);
  endtask

  // One iterative op: checks result, latency, busy span, in_ready.
  task automatic lat_op(input string tag, input logic [4:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   busy_n, rdy_n, lat;
    e = model(op, a, b);
    busy_n = 0;
    rdy_n = 0;
    lat = -1;
    @(negedge clk);
    bus.in_valid_i  = 1'b1;
    bus.op_i        = op;
    bus.rd_i        = a;
    bus.rs_i        = b;
    bus.out_ready_i = 1'b1;
    #1 chk({tag, ".acc"}, bus.in_ready_o, 1);
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      #1;
      if (bus.busy_o) busy_n++;
      if (bus.in_ready_o) rdy_n++;
      if (bus.out_valid_o) begin
        lat = k;
        chk({tag, ".res"}, bus.result_o, e.r);
      end
    end
    chk({tag, ".lat"}, lat, 33);
    chk({tag, ".busy"}, busy_n, 32);
    chk({tag, ".rdy"}, rdy_n, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int f, l, vcnt, pick;
    logic [W-1:0] sp [5];
    logic [4:0]   itop [$];
    stim_t s;
    sp[0] = 32'h0;
    sp[1] = 32'h1;
    sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000;
    sp[4] = 32'h7;
    itop = '{5'd18, 5'd19, 5'd20, 5'd21};
`ifdef ALU_SIGNED_MULDIV_EN
    itop.push_back(5'd22);
    itop.push_back(5'd23);
    itop.push_back(5'd24);
`endif

    // Reset held with a pending op
    bus.in_valid_i  = 1'b1;
    bus.op_i        = 5'd0;
    bus.rd_i        = 32'd5;
    bus.rs_i        = 32'd6;
    bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.valid", bus.out_valid_o, 0);
    chk("rst.res", bus.result_o, 0);
    chk("rst.busy", bus.busy_o, 0);
    chk("rst.jmp", bus.jump_now_o, 0);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    n_reset = 1'b1;
    #1 chk("rst.rdy", bus.in_ready_o, 1);

    // Single-cycle stream at full rate
    stim_q.push_back('{5'd0,  32'hFFFF_FFFF, 32'd1});
    stim_q.push_back('{5'd12, 32'h8000_0001, 32'd1});
    stim_q.push_back('{5'd11, 32'h1234_5678, 32'd0});
    stim_q.push_back('{5'd9,  32'hFFFF_FFFF, 32'd1});
    stim_q.push_back('{5'd10, 32'hFFFF_FFFF, 32'd1});
    stim_q.push_back('{5'd16, 32'h8000_0000, 32'd0});
    drive(100, 100, f, l);
    chk("thru", l - f, 5);
    chk("ror.const", model(5'd12, 32'h8000_0001, 32'd1).r,
        32'hC000_0000);

    // Iterative ops
    lat_op("mul",   5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lat_op("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lat_op("divu",  5'd20, 32'd100, 32'd7);
    lat_op("remu",  5'd21, 32'd100, 32'd7);
    lat_op("divu0", 5'd20, 32'hDEAD_BEEF, 32'd0);
    lat_op("remu0", 5'd21, 32'd5, 32'd0);

    // Backpressure: result held, next op waits
    @(negedge clk);
    bus.in_valid_i  = 1'b1;
    bus.op_i        = 5'd0;
    bus.rd_i        = 32'd3;
    bus.rs_i        = 32'd4;
    bus.out_ready_i = 1'b0;
    #1 chk("bp.acc", bus.in_ready_o, 1);
    repeat (5) begin
      @(negedge clk);
      bus.op_i = 5'd1;
      bus.rd_i = 32'd9;
      bus.rs_i = 32'd1;
      #1;
      chk("bp.valid", bus.out_valid_o, 1);
      chk("bp.hold", bus.result_o, 7);
      chk("bp.rdy", bus.in_ready_o, 0);
    end
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    #1 chk("bp.swap", bus.in_ready_o, 1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #1;
    chk("bp.nvalid", bus.out_valid_o, 1);
    chk("bp.next", bus.result_o, 8);

    // Reset in the middle of a divide
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.op_i       = 5'd20;
    bus.rd_i       = 32'd1000;
    bus.rs_i       = 32'd3;
    #1 chk("abort.acc", bus.in_ready_o, 1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    #1 chk("abort.busy0", bus.busy_o, 1);
    n_reset = 1'b0;
    #1;
    chk("abort.busy", bus.busy_o, 0);
    chk("abort.valid", bus.out_valid_o, 0);
    @(negedge clk);
    n_reset = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1 if (bus.out_valid_o) vcnt++;
    end
    chk("abort.none", vcnt, 0);

`ifdef ALU_SIGNED_MULDIV_EN
    lat_op("div",  5'd23, 32'hFFFF_FFF9, 32'd2);
    lat_op("rem",  5'd24, 32'hFFFF_FFF9, 32'd2);
    lat_op("ovf",  5'd23, 32'h8000_0000, 32'hFFFF_FFFF);
    lat_op("mulh", 5'd22, 32'hFFFF_FFFF, 32'd3);
`endif

    // Random mix with random backpressure
    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(99);
      if (pick < 20) s.op = itop[$urandom_range(itop.size() - 1)];
      else s.op = 5'($urandom_range(31));
      s.a = ($urandom_range(3) == 0) ? sp[$urandom_range(4)] : $urandom;
      s.b = ($urandom_range(3) == 0) ? sp[$urandom_range(4)] : $urandom;
      stim_q.push_back(s);
    end
    drive(70, 40000, f, l);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
